vram_writer: RTL and testbench
==============================

# vram_writer

Write-side companion of the video controller's VRAM read port. Snoops Z80 memory write cycles and snapshot-loader writes, keeps only bytes landing in the screen banks (RAM bank 5 → VRAM half 0, bank 7 → VRAM half 1), and funnels them through a small FIFO into the single VRAM write port. The result is a 15-bit VRAM image that the video block reads back with the same addressing.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 4.
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- addr  in  16  CPU address bus.
- din  in  8  CPU data out.
- nMREQ, nWR, nRFSH  in  1 each  CPU strobes, active-low.
- m128  in  1  128K paging enabled.
- page_ram  in  3  RAM bank mapped at 0xC000.
- ld_wr  in  1  loader write request; held with data until accepted.
- ld_addr  in  17  loader byte address in 128K RAM; [16:14] = bank.
- ld_data  in  8  loader data.
- ld_wait  out  1  loader back-pressure.
- vram_req  out  1  FIFO head valid.
- vram_ack  in  1  VRAM port accepts head this cycle.
- vram_waddr  out  15  head address, {half, offset[13:0]}.
- vram_wdata  out  8  head data.
- overflow  out  1  sticky flag: a CPU screen write was dropped.

## Operation
- CPU write condition: wc = ~nMREQ & ~nWR & nRFSH. It is registered every clk_sys as wc_q.
- A capture (cpu_cap) occurs on the cycle where wc & ~wc_q, using the addr and din values present in that cycle.
- CPU mapping:
  - addr[15:14]=01 → {0, addr[13:0]}.
  - addr[15:14]=11 & m128 & page_ram=5 → {0, addr[13:0]}.
  - addr[15:14]=11 & m128 & page_ram=7 → {1, addr[13:0]}.
  - Any other address → no push.
- Loader mapping:
  - ld_addr[16:14]=5 → {0, ld_addr[13:0]}.
  - ld_addr[16:14]=7 → {1, ld_addr[13:0]}.
  - Other banks: the write is accepted and discarded.
- Loader write is accepted when ld_wr & ~ld_wait. ld_wait = cpu_cap | (count ≥ DEPTH-1), combinational. This keeps one entry reserved for the CPU.
- CPU push when count = DEPTH with no pop in the same cycle: the byte is dropped and overflow is set. overflow clears only on reset.
- Same-cycle CPU capture and loader request: CPU pushes; loader is stalled by ld_wait.
- Pop occurs when vram_req & vram_ack. Push and pop in the same cycle are both performed and count is unchanged. This applies even when the FIFO is full.
- FIFO preserves strict arrival order.
- No bypass path. vram_waddr and vram_wdata are driven from the FIFO head and held stable while vram_req & ~vram_ack.

## Timing
- Reset values: count=0, vram_req=0, vram_waddr=0, vram_wdata=0, overflow=0, ld_wait=0 (cpu_cap is impossible in reset).
- wc_q resets to 1, so a write already in progress at reset release is not captured.
- Latency: capture or loader accept in cycle N → entry written at edge N → vram_req=1 in cycle N+1 if the FIFO was empty.
- Throughput: one pop per cycle while vram_ack is held high.
- One capture per CPU write cycle, regardless of how long nWR stays low.
- Reset mid-operation: FIFO flushed, queued bytes lost, and no vram_req in the cycle after reset.
- Count width: $clog2(DEPTH)+1. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Structure
- Package vram_pkg holds:
  - SCR_BANK0=3'd5 and SCR_BANK1=3'd7.
  - typedef vram_wr_t = struct {logic [14:0] addr; logic [7:0] data;}.
  - The CPU and loader mapping functions, shared with the video block's page decode.
- Sub-module vram_wfifo: generic synchronous FIFO of vram_wr_t. It has push/pop/count outputs and no internal policy. Push-priority muxing, the ld_wait logic and overflow live in vram_writer.

## Test plan
- 48K mode: CPU writes 0xAA to 0x4000 with vram_ack=1 → exactly one vram_req pulse, waddr=0x0000, wdata=0xAA, one cycle after capture.
- m128=1, page_ram=7: CPU writes 0x5C to 0xC123 → waddr=0x4123, wdata=0x5C.
- Ignored writes, each → no vram_req:
  - page_ram=3 write to 0xC123.
  - m128=0 write to 0xC000.
  - A refresh cycle (nRFSH=0) with nMREQ low.
- vram_ack=0, loader streams bank 5 offsets 0,1,2,3 → ld_wait rises after 3 accepts. Releasing ack yields 0x0000, 0x0001, 0x0002 in order, then 0x0003 is accepted.
- vram_ack=0, five CPU screen writes → 4 entries queued, overflow=1. After draining, the 4 bytes emerge in order and overflow stays 1 until reset.
- CPU capture coincident with loader ld_wr to bank 7 → CPU entry precedes loader entry, ld_wait high that cycle. Asserting reset mid-queue → vram_req=0 next cycle, overflow=0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared screen-bank constants, VRAM write record and the CPU/loader page decode
// used by both the VRAM writer and the video block.
package vram_pkg;

    localparam logic [2:0] SCR_BANK0 = 3'd5;
    localparam logic [2:0] SCR_BANK1 = 3'd7;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } vram_wr_t;

    typedef struct packed {
        logic        hit;
        logic [14:0] addr;
    } vram_map_t;

    function automatic vram_map_t cpu_map(input logic [15:0] addr, input logic m128,
                                          input logic [2:0] page_ram);
        vram_map_t m;
        m.hit  = 1'b0;
        m.addr = {1'b0, addr[13:0]};
        if (addr[15:14] == 2'b01) begin
            m.hit = 1'b1;
        end else if (addr[15:14] == 2'b11 && m128) begin
            if (page_ram == SCR_BANK0) begin
                m.hit = 1'b1;
            end else if (page_ram == SCR_BANK1) begin
                m.hit     = 1'b1;
                m.addr[14] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic vram_map_t ld_map(input logic [16:0] ld_addr);
        vram_map_t m;
        m.hit  = (ld_addr[16:14] == SCR_BANK0) || (ld_addr[16:14] == SCR_BANK1);
        m.addr = {ld_addr[16:14] == SCR_BANK1, ld_addr[13:0]};
        return m;
    endfunction

endpackage

// File: rtl/vram_wfifo.sv
// Generic synchronous FIFO of VRAM write records; the caller guarantees it never
// pushes into a full FIFO unless it pops in the same cycle.
module vram_wfifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   i_push,
    input  vram_wr_t               i_wr,
    input  logic                   i_pop,
    output vram_wr_t               o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    vram_wr_t               r_mem [DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_count;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wr;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/vram_writer.sv
// Snoops CPU and loader writes, keeps screen-bank bytes and queues them toward the
// single VRAM write port.
module vram_writer
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        nMREQ,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic        m128,
    input  logic [2:0]  page_ram,
    input  logic        ld_wr,
    input  logic [16:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_wait,
    output logic        vram_req,
    input  logic        vram_ack,
    output logic [14:0] vram_waddr,
    output logic [7:0]  vram_wdata,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic        r_wc_q;
    logic        r_overflow;
    logic        w_wc;
    logic        w_cpu_cap;
    vram_map_t   w_cpu_map;
    vram_map_t   w_ld_map;
    logic        w_cpu_req;
    logic        w_cpu_push;
    logic        w_cpu_drop;
    logic        w_ld_push;
    logic        w_ld_wait;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    vram_wr_t    w_wr;
    vram_wr_t    w_head;
    logic [CW-1:0] w_count;

    assign w_wc      = ~nMREQ & ~nWR & nRFSH;
    // Rising edge of the write strobe only, so a long nWR yields a single capture.
    assign w_cpu_cap = w_wc & ~r_wc_q & ~reset;
    assign w_cpu_map = cpu_map(addr, m128, page_ram);
    assign w_ld_map  = ld_map(ld_addr);

    assign w_full     = (w_count == CW'(DEPTH));
    assign w_pop      = vram_req & vram_ack;
    assign w_cpu_req  = w_cpu_cap & w_cpu_map.hit;
    assign w_cpu_push = w_cpu_req & (~w_full | w_pop);
    assign w_cpu_drop = w_cpu_req & w_full & ~w_pop;

    // The loader stops one entry short of full so a CPU write always has room.
    assign w_ld_wait = w_cpu_cap | (w_count >= CW'(DEPTH - 1));
    assign w_ld_push = ld_wr & ~w_ld_wait & w_ld_map.hit;

    assign w_push = w_cpu_push | w_ld_push;
    assign w_wr   = w_cpu_cap ? '{addr: w_cpu_map.addr, data: din}
                              : '{addr: w_ld_map.addr, data: ld_data};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wc_q     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wc_q <= w_wc;
            if (w_cpu_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    vram_wfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_push  (w_push),
        .i_wr    (w_wr),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign ld_wait    = w_ld_wait;
    assign vram_req   = (w_count != '0);
    assign vram_waddr = w_head.addr;
    assign vram_wdata = w_head.data;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: CPU/loader mapping, FIFO ordering, back-pressure,
// overflow and reset flush.
module tb_vram_writer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        nMREQ, nWR, nRFSH;
    logic        m128;
    logic [2:0]  page_ram;
    logic        ld_wr;
    logic [16:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_wait;
    logic        vram_req;
    logic        vram_ack;
    logic [14:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;
    int req_cycles  = 0;
    int base;

    vram_writer #(
        .DEPTH (4)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .addr       (addr),
        .din        (din),
        .nMREQ      (nMREQ),
        .nWR        (nWR),
        .nRFSH      (nRFSH),
        .m128       (m128),
        .page_ram   (page_ram),
        .ld_wr      (ld_wr),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_wait    (ld_wait),
        .vram_req   (vram_req),
        .vram_ack   (vram_ack),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (vram_req === 1'b1) req_cycles++;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_start(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        din   = d;
        nMREQ = 1'b0;
        nWR   = 1'b0;
    endtask

    task automatic cpu_end();
        nMREQ = 1'b1;
        nWR   = 1'b1;
    endtask

    // Full CPU write: strobes low for one cycle, then idle one cycle.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_start(a, d);
        tick();
        cpu_end();
        tick();
    endtask

    initial begin
        reset = 1'b1; addr = '0; din = '0; nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
        m128 = 1'b0; page_ram = 3'd0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
        vram_ack = 1'b1;
        tick(); tick();
        sample();
        check("rst_req", vram_req, 0);
        check("rst_waddr", vram_waddr, 0);
        check("rst_wdata", vram_wdata, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ld_wait", ld_wait, 0);
        tick();
        reset = 1'b0;
        tick();

        // 48K screen write, nWR held low for two cycles.
        base = req_cycles;
        cpu_start(16'h4000, 8'hAA);
        sample();
        check("t1_cap_wait", ld_wait, 1);
        check("t1_req_before", vram_req, 0);
        tick();
        sample();
        check("t1_req", vram_req, 1);
        check("t1_waddr", vram_waddr, 15'h0000);
        check("t1_wdata", vram_wdata, 8'hAA);
        tick();
        sample();
        check("t1_req_gone", vram_req, 0);
        cpu_end();
        tick(); tick();
        check("t1_one_pulse", req_cycles - base, 1);

        // 128K, bank 7 at 0xC000.
        m128 = 1'b1; page_ram = 3'd7;
        cpu_start(16'hC123, 8'h5C);
        tick();
        sample();
        check("t2_waddr", vram_waddr, 15'h4123);
        check("t2_wdata", vram_wdata, 8'h5C);
        cpu_end();
        tick(); tick();

        // Writes that must not reach VRAM.
        base = req_cycles;
        page_ram = 3'd3;
        cpu_write(16'hC123, 8'h11);
        tick();
        check("ign_bank3", req_cycles - base, 0);
        m128 = 1'b0; page_ram = 3'd5;
        cpu_write(16'hC000, 8'h22);
        tick();
        check("ign_48k_c000", req_cycles - base, 0);
        nRFSH = 1'b0;
        cpu_write(16'h4000, 8'h33);
        nRFSH = 1'b1;
        tick();
        check("ign_refresh", req_cycles - base, 0);
        ld_wr = 1'b1; ld_addr = {3'd2, 14'h0010}; ld_data = 8'h44;
        sample();
        check("ld_bank2_accept", ld_wait, 0);
        tick();
        ld_wr = 1'b0;
        tick();
        check("ld_bank2_discard", req_cycles - base, 0);

        // Loader back-pressure with VRAM stalled.
        vram_ack = 1'b0;
        ld_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_addr = {3'd5, 14'(i)}; ld_data = 8'(8'h10 + i);
            sample();
            check($sformatf("ld_accept%0d", i), ld_wait, 0);
            tick();
        end
        ld_addr = {3'd5, 14'd3}; ld_data = 8'h13;
        sample();
        check("ld_wait_full", ld_wait, 1);
        tick();
        vram_ack = 1'b1;
        sample();
        check("ld_head0", vram_waddr, 15'h0000);
        check("ld_data0", vram_wdata, 8'h10);
        check("ld_wait_hold", ld_wait, 1);
        tick();
        sample();
        check("ld_head1", vram_waddr, 15'h0001);
        check("ld_wait_free", ld_wait, 0);
        tick();
        ld_wr = 1'b0;
        sample();
        check("ld_head2", vram_waddr, 15'h0002);
        tick();
        sample();
        check("ld_head3", vram_waddr, 15'h0003);
        check("ld_data3", vram_wdata, 8'h13);
        tick();
        sample();
        check("ld_drained", vram_req, 0);

        // CPU overflow: five screen writes into a depth-4 FIFO.
        vram_ack = 1'b0;
        for (int i = 0; i < 4; i++) cpu_write(16'h4000 + 16'(i), 8'(8'hA0 + i));
        check("ovf_not_yet", overflow, 0);
        cpu_write(16'h4004, 8'hA4);
        check("ovf_set", overflow, 1);
        // Push and pop together while full: both take effect.
        vram_ack = 1'b1;
        cpu_start(16'h4010, 8'hEE);
        sample();
        check("ovf_head0", {vram_waddr, vram_wdata}, {15'h0000, 8'hA0});
        tick();
        cpu_end();
        for (int i = 1; i < 4; i++) begin
            sample();
            check($sformatf("ovf_head%0d", i), {vram_waddr, vram_wdata},
                  {15'(i), 8'(8'hA0 + i)});
            tick();
        end
        sample();
        check("ovf_full_push", {vram_waddr, vram_wdata}, {15'h0010, 8'hEE});
        tick();
        sample();
        check("ovf_drained", vram_req, 0);
        check("ovf_sticky", overflow, 1);

        // CPU capture coincident with loader request.
        vram_ack = 1'b0;
        tick();
        cpu_start(16'h4005, 8'h77);
        ld_wr = 1'b1; ld_addr = {3'd7, 14'h0012}; ld_data = 8'h33;
        sample();
        check("coin_ld_wait", ld_wait, 1);
        tick();
        sample();
        check("coin_ld_go", ld_wait, 0);
        tick();
        ld_wr = 1'b0;
        cpu_end();
        sample();
        check("coin_head_cpu", {vram_waddr, vram_wdata}, {15'h0005, 8'h77});
        tick();
        vram_ack = 1'b1;
        sample();
        check("coin_hold", {vram_waddr, vram_wdata}, {15'h0005, 8'h77});
        tick();
        vram_ack = 1'b0;
        sample();
        check("coin_head_ld", {vram_req, vram_waddr, vram_wdata}, {1'b1, 15'h4012, 8'h33});
        cpu_write(16'h4020, 8'h99);
        reset = 1'b1;
        tick();
        sample();
        check("rst_mid_req", vram_req, 0);
        check("rst_mid_ovf", overflow, 0);

        // Write already in progress when reset releases is not captured.
        cpu_start(16'h4000, 8'h55);
        tick();
        reset = 1'b0;
        base = req_cycles;
        tick(); tick();
        cpu_end();
        tick();
        check("rst_inflight", req_cycles - base, 0);
        check("rst_flushed", vram_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
